// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the register file's single write port among three
//            writeback sources (0 = ALU, 1 = load unit, 2 = mul/div).
//            It grants one write per cycle using fixed priority, and it
//            promotes any requester that has stalled too long. Writes to $0
//            and overflow-flagged writes are suppressed. A pending-write
//            scoreboard lets issue logic detect RAW/WAW hazards.
// Ports    : CLK, RST_n (async, active-high reset)
//            req_valid/req_addr/req_data/req_ov  packed requests
//            req_ready   combinational one-hot-or-zero grant
//            rsv_valid/rsv_addr                  scoreboard reservation
//            rf_we/rf_waddr/rf_wdata             registered write port
//            pending     scoreboard bits, drop_cnt overflow drops
// Revision : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int AGE_LIMIT = 4,
    parameter int DW        = 32,
    parameter int AW        = 5
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [2:0]        req_valid,
    input  logic [3*AW-1:0]   req_addr,
    input  logic [3*DW-1:0]   req_data,
    input  logic [2:0]        req_ov,
    output logic [2:0]        req_ready,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [31:0]       pending,
    output logic [7:0]        drop_cnt
);

    logic [2:0]    aged;
    logic [2:0]    gnt;
    logic          xfer;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_ov;

    logic          rf_we_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;
    logic [31:0]   pending_q, pending_d;
    logic [7:0]    drop_q, drop_d;

    // Per-requester wait counters. A requester is "aged" once it has been
    // valid and stalled for AGE_LIMIT consecutive cycles.
    for (genvar i = 0; i < 3; i++) begin : g_wait
        logic [2:0] wait_q;

        always_ff @(posedge CLK or posedge RST_n) begin
            if (RST_n)
                wait_q <= 3'd0;
            else if (!req_valid[i] || gnt[i])
                wait_q <= 3'd0;
            else if (wait_q < 3'(AGE_LIMIT))
                wait_q <= wait_q + 3'd1;
        end

        assign aged[i] = req_valid[i] && (wait_q == 3'(AGE_LIMIT));
    end

    // Aged requesters take precedence over the plain fixed-priority order.
    always_comb begin
        gnt = 3'b000;
        if (|aged) begin
            if (aged[0])      gnt = 3'b001;
            else if (aged[1]) gnt = 3'b010;
            else              gnt = 3'b100;
        end else if (req_valid[0]) begin
            gnt = 3'b001;
        end else if (req_valid[1]) begin
            gnt = 3'b010;
        end else if (req_valid[2]) begin
            gnt = 3'b100;
        end
        if (RST_n)
            gnt = 3'b000;
    end

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // gnt is one-hot or zero, so the last match is the only match.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_ov   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
                sel_ov   = req_ov[i];
            end
        end
    end

    // The reserve is applied after the clear, so a same-edge reservation
    // for a newer instruction wins over the retiring write.
    always_comb begin
        pending_d = pending_q;
        for (int r = 1; r < 32; r++) begin
            if (xfer && (sel_addr == AW'(r)))
                pending_d[r] = 1'b0;
            if (rsv_valid && (rsv_addr == AW'(r)))
                pending_d[r] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Writes to $0 are discarded silently and never counted as drops.
    always_comb begin
        drop_d = drop_q;
        if (xfer && sel_ov && (sel_addr != '0) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RST_n) begin
        if (RST_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            if (xfer) begin
                rf_we_q    <= (sel_addr != '0) && !sel_ov;
                rf_waddr_q <= sel_addr;
                rf_wdata_q <= sel_data;
            end else begin
                rf_we_q    <= 1'b0;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;
    assign drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (we/waddr/wdata) among three writeback sources: 0 = ALU, 1 = load unit, 2 = multiply/divide unit.
- Arbitrates one write per cycle, with starvation protection, and suppresses writes on overflow or to $0.
- Keeps a pending-write scoreboard so issue logic can detect RAW/WAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- AGE_LIMIT, 4: consecutive stalled cycles after which a requester is promoted to top priority (legal range 1..7).
- DW, 32: data width.
- AW, 5: register address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_n  in  1  reset; asynchronous, active-high.
- req_valid  in  3  per-requester write request.
- req_addr  in  3*AW  packed destination addresses; requester i uses bits [i*AW +: AW].
- req_data  in  3*DW  packed write data; requester i uses bits [i*DW +: DW].
- req_ov  in  3  per-requester overflow flag; 1 = suppress the write.
- req_ready  out  3  grant, one-hot or zero, combinational.
- rsv_valid  in  1  scoreboard reserve strobe from issue.
- rsv_addr  in  AW  register to mark pending.
- rf_we  out  1  register file write enable.
- rf_waddr  out  AW  register file write address.
- rf_wdata  out  DW  register file write data.
- pending  out  32  scoreboard bit per register; bit 0 is always 0.
- drop_cnt  out  8  saturating count of overflow-suppressed writes.

Behaviour:
- Reset (RST_n=1, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pending=0, drop_cnt=0, all wait counters cleared.
  - req_ready=0 for as long as RST_n=1.
- Reset mid-operation: any registered write not yet presented is discarded. No write appears after RST_n falls until a new transfer occurs.
- Arbitration (combinational, every cycle):
  - Aged set = requesters with req_valid=1 and wait counter == AGE_LIMIT.
  - If the aged set is non-empty, grant its lowest index.
  - Otherwise, fixed priority 0 > 1 > 2 among valid requesters.
  - At most one req_ready bit is high. req_ready[i] is never high while req_valid[i]=0.
- Transfer: req_valid[i] & req_ready[i] at a rising edge.
- Requester protocol: a requester holds valid, addr, data and ov stable until it is granted.
- Throughput: 1 write/cycle; the output stage never back-pressures.
- Wait counters (3 bits, one per requester):
  - Increment when valid=1 and not granted, saturating at AGE_LIMIT.
  - Clear on grant or when valid=0.
- Output stage (latency 1: the edge that completes the transfer loads these outputs):
  - rf_waddr = addr, rf_wdata = data.
  - rf_we = 1 only if addr != 0 and ov = 0.
  - With no transfer, rf_we = 0 next cycle; rf_waddr and rf_wdata hold their previous values.
- Drop counter: a transfer with ov=1 increments drop_cnt, saturating at 255. A write to $0 is dropped silently and not counted.
- Scoreboard:
  - rsv_valid=1 and rsv_addr != 0 sets pending[rsv_addr] at the edge.
  - A transfer to addr clears pending[addr] at the same edge, even if the write was suppressed for overflow.
  - Simultaneous set and clear of the same register: set wins (a newer reservation is outstanding).
  - Reserving a register that is already pending leaves it at 1.
  - Reserve of 0 is ignored; pending[0] is tied to 0.
- Simultaneous events: different requesters targeting the same register are serialized in grant order, so the last granted value is what gets written.

Test Plan:
- Priority: all three valid in the same cycle (addrs 5/6/7, data A/B/C) → grants 0, 1, 2 on consecutive cycles. rf_we pulses for 3 cycles starting 1 cycle after the first grant; writes are $5=A, $6=B, $7=C in that order.
- Starvation: req 0 and req 1 held valid continuously, AGE_LIMIT=4 → req 1 is granted on its 5th valid cycle. Its counter then clears and req 0 resumes.
- Overflow: req 1 with addr 9, ov=1, pending[9]=1 → rf_we=0 next cycle, drop_cnt 0→1, pending[9] clears. Repeat 300 times → drop_cnt=255.
- $0 and scoreboard race:
  - rsv_addr=0 → pending stays 0.
  - Write to $0 → rf_we=0 and drop_cnt unchanged.
  - rsv_addr=12 in the same cycle as a transfer to $12 → pending[12]=1 afterwards.
- Async reset mid-transfer: RST_n raised between the grant edge and the output cycle, and drop_cnt=17 → rf_we=0 immediately, pending=0, drop_cnt=0. No write appears after release until a new request is issued.
